// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and HI/LO
// interlocks, branch/jump flush, multiply/divide busy sequencing, stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [15:0] perf_stalls
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

  state_t      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [15:0] perf_q, perf_d;

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic       md_op, hilo_use, jump, uses_rt;
  logic       load_use, md_hazard, stall, issue;

  always_comb begin
    op       = id_instr[31:26];
    rs       = id_instr[25:21];
    rt       = id_instr[20:16];
    fn       = id_instr[5:0];
    md_op    = (op == 6'h00) && (fn[5:2] == 4'b0110);
    hilo_use = (op == 6'h00) && (fn[5:2] == 4'b0100);
    jump     = (op == 6'h02) || (op == 6'h03);
    uses_rt  = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    load_use = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    md_hazard = (state_q == BUSY) && (md_op || hilo_use);
    stall     = load_use || md_hazard;
    issue     = md_op && !stall && !ex_branch_taken;
  end

  // Pipeline controls are combinational but held low while reset is asserted.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (jump) begin
      ifid_flush  = 1'b1;
    end
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          md_cnt_d = fn[1] ? DIV_CNT : MULT_CNT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        md_cnt_d = md_cnt_q - 6'd1;
        if (md_cnt_q == 6'd1) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (stall && !ex_branch_taken && (perf_q != '1)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      perf_q   <= perf_d;
    end
  end

  assign md_busy     = (state_q == BUSY);
  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: decode/priority vector table plus
// multi-cycle sequences for mul/div interlock, jumps, reset and saturation.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, md_busy;
  logic [15:0] perf_stalls;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_instr        (id_instr),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .md_busy         (md_busy),
    .perf_stalls     (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rt;
    logic        br;
    logic [3:0]  ctl;   // {pc_we, ifid_we, ifid_flush, idex_bubble}
  } vec_t;

  localparam logic [3:0] C_NORM  = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_JUMP  = 4'b1110;
  localparam logic [3:0] C_BR    = 4'b1111;

  logic [31:0] i_add, i_sw, i_lw, i_addi, i_beq, i_j, i_jrs5, i_mult, i_div, i_mflo, i_mfhi, i_nop;
  vec_t        tbl [15];
  int          perf_exp;
  int          stalls, busy_n, issue_at;
  logic        issued;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {pc_we, ifid_we, ifid_flush, idex_bubble};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic mr, input logic [4:0] rt, input logic br);
    id_instr        = instr;
    ex_mem_read     = mr;
    ex_rt           = rt;
    ex_branch_taken = br;
  endtask

  initial begin
    i_add  = {6'h00, 5'd5, 5'd2, 5'd3, 5'd0, 6'h20};
    i_sw   = {6'h2B, 5'd6, 5'd5, 16'h0000};
    i_lw   = {6'h23, 5'd6, 5'd5, 16'h0000};
    i_addi = {6'h08, 5'd1, 5'd5, 16'h0001};
    i_beq  = {6'h04, 5'd1, 5'd5, 16'h0003};
    i_j    = {6'h02, 26'h0000010};
    i_jrs5 = {6'h02, 5'd5, 21'h000010};
    i_mult = {6'h00, 5'd4, 5'd5, 5'd0, 5'd0, 6'h18};
    i_div  = {6'h00, 5'd4, 5'd5, 5'd0, 5'd0, 6'h1A};
    i_mflo = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h12};
    i_mfhi = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h10};
    i_nop  = 32'h0;

    tbl[0]  = '{"lu_rs",      i_add,  1'b1, 5'd5, 1'b0, C_STALL};
    tbl[1]  = '{"lu_rt0",     i_add,  1'b1, 5'd0, 1'b0, C_NORM};
    tbl[2]  = '{"no_load",    i_add,  1'b0, 5'd5, 1'b0, C_NORM};
    tbl[3]  = '{"lu_rt_rtype",i_add,  1'b1, 5'd2, 1'b0, C_STALL};
    tbl[4]  = '{"lu_sw_rt",   i_sw,   1'b1, 5'd5, 1'b0, C_STALL};
    tbl[5]  = '{"lw_rt_free", i_lw,   1'b1, 5'd5, 1'b0, C_NORM};
    tbl[6]  = '{"lu_lw_rs",   i_lw,   1'b1, 5'd6, 1'b0, C_STALL};
    tbl[7]  = '{"addi_rt",    i_addi, 1'b1, 5'd5, 1'b0, C_NORM};
    tbl[8]  = '{"lu_beq_rt",  i_beq,  1'b1, 5'd5, 1'b0, C_STALL};
    tbl[9]  = '{"jump",       i_j,    1'b0, 5'd0, 1'b0, C_JUMP};
    tbl[10] = '{"jump_stall", i_jrs5, 1'b1, 5'd5, 1'b0, C_STALL};
    tbl[11] = '{"br_over_lu", i_add,  1'b1, 5'd5, 1'b1, C_BR};
    tbl[12] = '{"br_mult",    i_mult, 1'b0, 5'd0, 1'b1, C_BR};
    tbl[13] = '{"mult_lu",    i_mult, 1'b1, 5'd4, 1'b0, C_STALL};
    tbl[14] = '{"mflo_idle",  i_mflo, 1'b0, 5'd0, 1'b0, C_NORM};

    // Reset state
    rst_n = 1'b0;
    drive(i_nop, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_busy", 32'(md_busy), 32'h0);
    chk("rst_perf", 32'(perf_stalls), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    perf_exp = 0;

    // Decode and priority table, one clock per vector
    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].instr, tbl[i].mr, tbl[i].rt, tbl[i].br);
      #1;
      chk(tbl[i].name, 32'(ctl()), 32'(tbl[i].ctl));
      if (tbl[i].ctl == C_STALL) perf_exp++;
    end
    @(negedge clk);
    drive(i_nop, 1'b0, 5'd0, 1'b0);
    #1;
    chk("tbl_perf", 32'(perf_stalls), 32'(perf_exp));
    chk("tbl_no_issue", 32'(md_busy), 32'h0);

    // Load-use stalls one cycle, then the bubble clears ex_mem_read
    @(negedge clk);
    drive(i_add, 1'b1, 5'd5, 1'b0);
    #1 chk("lu_seq_stall", 32'(ctl()), 32'(C_STALL));
    perf_exp++;
    @(negedge clk);
    drive(i_add, 1'b0, 5'd0, 1'b0);
    #1 chk("lu_seq_next", 32'(ctl()), 32'(C_NORM));
    chk("lu_seq_perf", 32'(perf_stalls), 32'(perf_exp));

    // MULT then MFLO
    @(negedge clk);
    drive(i_mult, 1'b0, 5'd0, 1'b0);
    #1 chk("mult_issue", 32'(ctl()), 32'(C_NORM));
    @(negedge clk);
    drive(i_mflo, 1'b0, 5'd0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (pc_we) break;
      if (!md_busy) chk("mflo_busy_during_stall", 32'(md_busy), 32'h1);
      stalls++;
      @(negedge clk);
    end
    perf_exp += 4;
    chk("mflo_stalls", 32'(stalls), 32'd4);
    chk("mult_busy_end", 32'(md_busy), 32'h0);
    chk("mflo_release", 32'(ctl()), 32'(C_NORM));
    chk("mflo_perf", 32'(perf_stalls), 32'(perf_exp));

    // DIV followed by a second DIV
    @(negedge clk);
    drive(i_div, 1'b0, 5'd0, 1'b0);
    #1 chk("div1_issue", 32'(ctl()), 32'(C_NORM));
    stalls = 0; busy_n = 0; issued = 1'b0; issue_at = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      drive(issued ? i_nop : i_div, 1'b0, 5'd0, 1'b0);
      #1;
      if (md_busy) busy_n++;
      if (!pc_we) stalls++;
      if (!issued && pc_we) begin
        issued = 1'b1;
        issue_at = i;
      end
    end
    perf_exp += 32;
    chk("div2_stalls", 32'(stalls), 32'd32);
    chk("div2_issue_cycle", 32'(issue_at), 32'd32);
    chk("div_busy_total", 32'(busy_n), 32'd64);
    chk("div_perf", 32'(perf_stalls), 32'(perf_exp));

    // Jump held by a stall applies its flush when released
    @(negedge clk);
    drive(i_jrs5, 1'b1, 5'd5, 1'b0);
    #1 chk("jmp_held", 32'(ctl()), 32'(C_STALL));
    perf_exp++;
    @(negedge clk);
    drive(i_jrs5, 1'b0, 5'd0, 1'b0);
    #1 chk("jmp_release", 32'(ctl()), 32'(C_JUMP));
    chk("jmp_perf", 32'(perf_stalls), 32'(perf_exp));

    // Reset asserted ten cycles into a DIV
    @(negedge clk);
    drive(i_div, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(i_nop, 1'b0, 5'd0, 1'b0);
    repeat (9) @(negedge clk);
    #1 chk("div_busy_mid", 32'(md_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(md_busy), 32'h0);
    chk("arst_ctl", 32'(ctl()), 32'h0);
    chk("arst_perf", 32'(perf_stalls), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(i_mfhi, 1'b0, 5'd0, 1'b0);
    #1 chk("mfhi_after_rst", 32'(ctl()), 32'(C_NORM));
    chk("busy_after_rst", 32'(md_busy), 32'h0);

    // Saturation of the stall counter
    @(negedge clk);
    drive(i_add, 1'b1, 5'd5, 1'b0);
    repeat (65534) @(negedge clk);
    #1 chk("perf_fffe", 32'(perf_stalls), 32'hFFFE);
    repeat (4466) @(negedge clk);
    #1 chk("perf_sat", 32'(perf_stalls), 32'hFFFF);
    chk("sat_still_stall", 32'(ctl()), 32'(C_STALL));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
